// File: rtl/qed_pkg.sv
// Shared definitions for the QED duplicate-instruction sequencer: mode encodings,
// SPARC instruction field positions, FSM states and the operand remap/legality helpers.
package qed_pkg;

  localparam int INST_W     = 33;
  localparam int REG_OFFSET = 16;
  localparam int REG_BIT    = $clog2(REG_OFFSET);

  localparam logic [1:0] ORIGINAL_MODE = 2'd0;
  localparam logic [1:0] DUP_MODE      = 2'd1;
  localparam logic [1:0] CHECK_MODE    = 2'd2;

  localparam logic [INST_W-1:0] NOP_INST = 33'h001000000;
  localparam logic [31:0]       NOP_BODY = 32'h01000000;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 30;
  localparam int RD_HI  = 29;
  localparam int RD_LO  = 25;
  localparam int OP2_HI = 24;
  localparam int OP2_LO = 22;
  localparam int OP3_HI = 24;
  localparam int OP3_LO = 19;
  localparam int RS1_HI = 18;
  localparam int RS1_LO = 14;
  localparam int I_BIT  = 13;
  localparam int RS2_HI = 4;
  localparam int RS2_LO = 0;

  typedef enum logic [1:0] {
    ST_ORIG,
    ST_DUP,
    ST_CHECK
  } state_e;

  // Shadow copy: register fields move to the upper half; control transfers become NOPs
  // (tag bit kept) so the replay can never redirect the fetch stream.
  function automatic logic [INST_W-1:0] remap_inst(input logic [INST_W-1:0] inst);
    logic [INST_W-1:0] r;
    r = inst;
    unique case (inst[OP_HI:OP_LO])
      2'b10, 2'b11: begin
        r[RD_LO+REG_BIT]  = 1'b1;
        r[RS1_LO+REG_BIT] = 1'b1;
        if (!inst[I_BIT]) begin
          r[RS2_LO+REG_BIT] = 1'b1;
        end
      end
      2'b00: begin
        if (inst[OP2_HI:OP2_LO] == 3'b100) begin
          if (inst[RD_HI:RD_LO] != 5'd0) begin
            r[RD_LO+REG_BIT] = 1'b1;
          end
        end else begin
          r = {inst[INST_W-1], NOP_BODY};
        end
      end
      default: r = {inst[INST_W-1], NOP_BODY};
    endcase
    return r;
  endfunction

  // Only fields the format actually uses as registers are checked.
  function automatic logic inst_legal(input logic [INST_W-1:0] inst);
    logic ok;
    ok = 1'b1;
    unique case (inst[OP_HI:OP_LO])
      2'b10, 2'b11: begin
        if (inst[RD_LO+REG_BIT] || inst[RS1_LO+REG_BIT]) begin
          ok = 1'b0;
        end
        if (!inst[I_BIT] && inst[RS2_LO+REG_BIT]) begin
          ok = 1'b0;
        end
      end
      2'b00: begin
        if ((inst[OP2_HI:OP2_LO] == 3'b100) && inst[RD_LO+REG_BIT]) begin
          ok = 1'b0;
        end
      end
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/qed_inst_fifo.sv
// Capture FIFO for original instructions; show-ahead read so the head entry is
// available in the same cycle it is popped.
module qed_inst_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 33
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/qed_dup_sequencer.sv
// QED sequencer: passes and captures originals, replays them on the shadow register
// half, then flags one check cycle for the downstream consistency checker.
module qed_dup_sequencer
  import qed_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ena,
  input  logic [INST_W-1:0]      ifu_inst,
  input  logic                   ifu_vld,
  input  logic                   stall,
  input  logic                   flush_req,
  output logic                   vld_inst,
  output logic [INST_W-1:0]      qed_inst,
  output logic                   qed_vld,
  output logic [1:0]             mode,
  output logic                   qed_illegal,
  output logic [$clog2(DEPTH):0] buf_count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e            state_q, state_d;
  logic [INST_W-1:0] qed_inst_q, qed_inst_d;
  logic              qed_vld_q, qed_vld_d;
  logic [1:0]        mode_q, mode_d;
  logic              illegal_q, illegal_d;

  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [INST_W-1:0] fifo_rdata;
  logic [CW-1:0]     fifo_count;
  logic              legal;

  qed_inst_fifo #(
    .DEPTH (DEPTH),
    .W     (INST_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (ifu_inst),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign legal = inst_legal(ifu_inst);

  // mode_q is registered with qed_inst so it labels the instruction currently on the output.
  always_comb begin
    state_d    = state_q;
    qed_inst_d = qed_inst_q;
    qed_vld_d  = qed_vld_q;
    mode_d     = mode_q;
    illegal_d  = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    if (!stall) begin
      unique case (state_q)
        ST_ORIG: begin
          mode_d     = ORIGINAL_MODE;
          qed_inst_d = NOP_INST;
          qed_vld_d  = 1'b0;
          if (ifu_vld) begin
            qed_vld_d = 1'b1;
            // With QED disabled there is no shadow half to protect, so nothing is illegal.
            if (ena && !legal) begin
              illegal_d = 1'b1;
            end else begin
              qed_inst_d = ifu_inst;
              push       = ena && !fifo_full;
            end
          end
          if (ena && ((push && (fifo_count == CNT_LAST)) ||
                      (flush_req && (push || !fifo_empty)))) begin
            state_d = ST_DUP;
          end
        end
        ST_DUP: begin
          mode_d    = DUP_MODE;
          qed_vld_d = 1'b0;
          if (!fifo_empty) begin
            pop        = 1'b1;
            qed_inst_d = remap_inst(fifo_rdata);
            qed_vld_d  = 1'b1;
          end
          if (fifo_count <= CNT_ONE) begin
            state_d = ST_CHECK;
          end
        end
        default: begin
          mode_d     = CHECK_MODE;
          qed_inst_d = NOP_INST;
          qed_vld_d  = 1'b0;
          state_d    = ST_ORIG;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ORIG;
      qed_inst_q <= NOP_INST;
      qed_vld_q  <= 1'b0;
      mode_q     <= ORIGINAL_MODE;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      qed_inst_q <= qed_inst_d;
      qed_vld_q  <= qed_vld_d;
      mode_q     <= mode_d;
      illegal_q  <= illegal_d;
    end
  end

  // Upstream may only issue once the output itself is back in original mode.
  assign vld_inst    = (state_q == ST_ORIG) && (mode_q == ORIGINAL_MODE);
  assign qed_inst    = qed_inst_q;
  assign qed_vld     = qed_vld_q;
  assign mode        = mode_q;
  assign qed_illegal = illegal_q;
  assign buf_count   = fifo_count;

endmodule

// File: tb/tb_qed_dup_sequencer.sv
// Self-checking bench for qed_dup_sequencer: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_qed_dup_sequencer;
  import qed_pkg::*;

  localparam int DEPTH = 8;
  localparam logic [32:0] C_NOP   = 33'h001000000;
  localparam logic [32:0] C_ADD   = 33'h082008003;
  localparam logic [32:0] C_ADDR  = 33'h0A2048013;
  localparam logic [32:0] C_ILL   = 33'h0A2008003;
  localparam logic [32:0] C_SETHI = 33'h003000010;
  localparam logic [32:0] C_SETHR = 33'h023000010;
  localparam logic [32:0] C_BA    = 33'h010800002;
  localparam logic [32:0] C_ADDI  = 33'h082002005;
  localparam logic [32:0] C_ADDIR = 33'h0A2042005;
  localparam logic [32:0] C_JUNK  = 33'h0C4000000;
  localparam logic [1:0]  M_O = ORIGINAL_MODE;
  localparam logic [1:0]  M_D = DUP_MODE;
  localparam logic [1:0]  M_C = CHECK_MODE;

  logic        clk = 1'b0;
  logic        rst, ena, ifu_vld, stall, flush_req;
  logic [32:0] ifu_inst;
  logic        vld_inst, qed_vld, qed_illegal;
  logic [32:0] qed_inst;
  logic [1:0]  mode;
  logic [3:0]  buf_count;

  int n_vec = 0;
  int n_err = 0;

  qed_dup_sequencer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .ifu_inst    (ifu_inst),
    .ifu_vld     (ifu_vld),
    .stall       (stall),
    .flush_req   (flush_req),
    .vld_inst    (vld_inst),
    .qed_inst    (qed_inst),
    .qed_vld     (qed_vld),
    .mode        (mode),
    .qed_illegal (qed_illegal),
    .buf_count   (buf_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ena, vld, stall, flush;
    logic [32:0] inst;
    logic [32:0] x_inst;
    logic        x_vld;
    logic [1:0]  x_mode;
    int          x_cnt;
    logic        x_ill, x_vi;
  } vec_t;

  vec_t vt[20];

  task automatic drive(input logic r, input logic e, input logic v, input logic s,
                       input logic f, input logic [32:0] in);
    rst = r; ena = e; ifu_vld = v; stall = s; flush_req = f; ifu_inst = in;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [32:0] xi, input logic xv,
                     input logic [1:0] xm, input int xc, input logic xill, input logic xvi);
    n_vec++;
    if (qed_inst !== xi || qed_vld !== xv || mode !== xm || int'(buf_count) != xc ||
        qed_illegal !== xill || vld_inst !== xvi) begin
      n_err++;
      $display("FAIL %s: got inst=%h vld=%b mode=%0d cnt=%0d ill=%b vi=%b, want inst=%h vld=%b mode=%0d cnt=%0d ill=%b vi=%b",
               name, qed_inst, qed_vld, mode, buf_count, qed_illegal, vld_inst,
               xi, xv, xm, xc, xill, xvi);
    end else begin
      $display("ok   %s: inst=%h vld=%b mode=%0d cnt=%0d", name, qed_inst, qed_vld, mode, buf_count);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_legal(input logic [32:0] x);
    int op, rd, rs1, rs2, op2;
    op = int'(x[31:30]); rd = int'(x[29:25]); rs1 = int'(x[18:14]);
    rs2 = int'(x[4:0]); op2 = int'(x[24:22]);
    if (op >= 2) return (rd < 16) && (rs1 < 16) && (x[13] || rs2 < 16);
    if (op == 0 && op2 == 4) return rd < 16;
    return 1'b1;
  endfunction

  function automatic logic [32:0] ref_remap(input logic [32:0] x);
    int op, rd, rs1, rs2, op2;
    logic [32:0] y;
    op = int'(x[31:30]); rd = int'(x[29:25]); rs1 = int'(x[18:14]);
    rs2 = int'(x[4:0]); op2 = int'(x[24:22]);
    y = x;
    if (op >= 2) begin
      rd = rd + 16; rs1 = rs1 + 16;
      if (!x[13]) rs2 = rs2 + 16;
      y[29:25] = 5'(rd); y[18:14] = 5'(rs1); y[4:0] = 5'(rs2);
    end else if (op == 0 && op2 == 4) begin
      if (rd != 0) rd = rd + 16;
      y[29:25] = 5'(rd);
    end else begin
      y = (x & 33'h100000000) | C_NOP;
    end
    return y;
  endfunction

  int          m_st;   // 0 original, 1 replay, 2 check
  logic [32:0] m_q[$];
  logic [32:0] e_inst;
  logic        e_vld, e_ill;
  logic [1:0]  e_mode;

  task automatic model_step();
    if (rst) begin
      m_q.delete(); m_st = 0; e_inst = C_NOP; e_vld = 0; e_mode = M_O; e_ill = 0;
      return;
    end
    e_ill = 0;
    if (stall) return;
    if (m_st == 0) begin
      e_mode = M_O;
      if (!ifu_vld) begin
        e_inst = C_NOP; e_vld = 0;
      end else if (ena && !ref_legal(ifu_inst)) begin
        e_inst = C_NOP; e_vld = 1; e_ill = 1;
      end else begin
        e_inst = ifu_inst; e_vld = 1;
        if (ena) m_q.push_back(ifu_inst);
      end
      if (ena && (m_q.size() == DEPTH || (flush_req && m_q.size() > 0))) m_st = 1;
    end else if (m_st == 1) begin
      e_mode = M_D;
      e_inst = ref_remap(m_q.pop_front());
      e_vld = 1;
      if (m_q.size() == 0) m_st = 2;
    end else begin
      e_mode = M_C; e_inst = C_NOP; e_vld = 0; m_st = 0;
    end
  endtask

  function automatic logic [32:0] rand_inst();
    logic [32:0] x;
    int k;
    x = 33'($urandom) | {1'($urandom_range(0, 1)), 32'h0};
    k = $urandom_range(0, 6);
    case (k)
      0, 1, 6: begin
        x[31:30] = (k == 6) ? 2'b11 : 2'b10;
        x[29:25] = 5'($urandom_range(0, 15));
        x[18:14] = 5'($urandom_range(0, 15));
        x[13]    = (k == 1);
        if (k != 1) x[4:0] = 5'($urandom_range(0, 15));
      end
      2: begin
        x[31:30] = 2'b10;
        x[13]    = 1'b0;
      end
      3: begin
        x[31:30] = 2'b00; x[24:22] = 3'b100;
        x[29:25] = 5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 31));
      end
      4: begin
        x[31:30] = 2'b00; x[24:22] = 3'b010;
      end
      default: x[31:30] = 2'b01;
    endcase
    return x;
  endfunction

  function automatic logic [32:0] dist_add(input int k);
    return 33'(64'h80000000 + (64'(k) << 25) + (64'd2 << 14) + 64'd3);
  endfunction

  function automatic logic [32:0] dist_rep(input int k);
    return 33'(64'h80000000 + (64'(k + 16) << 25) + (64'd18 << 14) + 64'd19);
  endfunction

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, C_NOP);
    tick();
    drive(0, 1, 0, 0, 0, C_NOP);
  endtask

  initial begin
    vt[0]  = '{0,0,1,0,0, C_ADD,   C_ADD,   1, M_O, 0, 0, 1};
    vt[1]  = '{0,0,0,0,0, C_NOP,   C_NOP,   0, M_O, 0, 0, 1};
    vt[2]  = '{0,1,1,0,0, C_ILL,   C_NOP,   1, M_O, 0, 1, 1};
    vt[3]  = '{0,1,0,0,0, C_NOP,   C_NOP,   0, M_O, 0, 0, 1};
    vt[4]  = '{0,0,1,0,0, C_ILL,   C_ILL,   1, M_O, 0, 0, 1};
    vt[5]  = '{0,0,1,0,0, C_ADD,   C_ADD,   1, M_O, 0, 0, 1};
    vt[6]  = '{0,1,1,1,0, C_JUNK,  C_ADD,   1, M_O, 0, 0, 1};
    vt[7]  = '{0,1,0,0,1, C_NOP,   C_NOP,   0, M_O, 0, 0, 1};
    vt[8]  = '{0,1,1,0,0, C_SETHI, C_SETHI, 1, M_O, 1, 0, 1};
    vt[9]  = '{0,1,1,0,0, C_BA,    C_BA,    1, M_O, 2, 0, 1};
    vt[10] = '{0,1,1,0,1, C_ADDI,  C_ADDI,  1, M_O, 3, 0, 0};
    vt[11] = '{0,1,1,0,0, C_JUNK,  C_SETHR, 1, M_D, 2, 0, 0};
    vt[12] = '{0,1,0,0,0, C_NOP,   C_NOP,   1, M_D, 1, 0, 0};
    vt[13] = '{0,1,0,0,0, C_NOP,   C_ADDIR, 1, M_D, 0, 0, 0};
    vt[14] = '{0,1,0,0,0, C_NOP,   C_NOP,   0, M_C, 0, 0, 0};
    vt[15] = '{0,1,0,0,0, C_NOP,   C_NOP,   0, M_O, 0, 0, 1};
    vt[16] = '{0,1,1,0,1, C_ADD,   C_ADD,   1, M_O, 1, 0, 0};
    vt[17] = '{0,1,0,0,0, C_NOP,   C_ADDR,  1, M_D, 0, 0, 0};
    vt[18] = '{0,1,0,0,0, C_NOP,   C_NOP,   0, M_C, 0, 0, 0};
    vt[19] = '{0,1,0,0,0, C_NOP,   C_NOP,   0, M_O, 0, 0, 1};

    drive(1, 0, 0, 0, 0, C_NOP);
    tick(); tick();
    chk("reset", C_NOP, 0, M_O, 0, 0, 1);

    for (int i = 0; i < 20; i++) begin
      drive(vt[i].rst, vt[i].ena, vt[i].vld, vt[i].stall, vt[i].flush, vt[i].inst);
      tick();
      chk($sformatf("vec%0d", i), vt[i].x_inst, vt[i].x_vld, vt[i].x_mode,
          vt[i].x_cnt, vt[i].x_ill, vt[i].x_vi);
    end

    // Fill to full, replay eight shadows (upstream junk ignored), check, back to original.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 1, 0, 0, C_ADD);
      tick();
      chk($sformatf("fill%0d", i), C_ADD, 1, M_O, i + 1, 0, (i < DEPTH - 1));
    end
    for (int k = 0; k < DEPTH; k++) begin
      drive(0, 1, 1, 0, 0, C_JUNK);
      tick();
      chk($sformatf("replay%0d", k), C_ADDR, 1, M_D, DEPTH - 1 - k, 0, 0);
    end
    drive(0, 1, 0, 0, 0, C_NOP);
    tick();
    chk("check_cycle", C_NOP, 0, M_C, 0, 0, 0);
    tick();
    chk("back_orig", C_NOP, 0, M_O, 0, 0, 1);

    // Stall mid-replay with distinct entries: nothing lost or repeated.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 1, 0, 0, dist_add(i));
      tick();
    end
    drive(0, 1, 0, 0, 0, C_NOP);
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 3) begin
        drive(0, 1, 0, 1, 0, C_NOP);
        for (int s = 0; s < 3; s++) begin
          tick();
          chk($sformatf("stall_hold%0d", s), dist_rep(2), 1, M_D, DEPTH - 3, 0, 0);
        end
        drive(0, 1, 0, 0, 0, C_NOP);
      end
      tick();
      chk($sformatf("stall_pop%0d", k), dist_rep(k), 1, M_D, DEPTH - 1 - k, 0, 0);
    end
    tick();
    chk("stall_check", C_NOP, 0, M_C, 0, 0, 0);

    // Reset after three pops aborts the replay and empties the FIFO.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1, 1, 0, 0, dist_add(i));
      tick();
    end
    drive(0, 1, 0, 0, 0, C_NOP);
    for (int k = 0; k < 3; k++) tick();
    chk("pre_rst_pop", dist_rep(2), 1, M_D, DEPTH - 3, 0, 0);
    drive(1, 1, 0, 0, 0, C_NOP);
    tick();
    chk("rst_mid_dup", C_NOP, 0, M_O, 0, 0, 1);
    drive(0, 1, 1, 0, 0, C_ADD);
    tick();
    chk("post_rst_push", C_ADD, 1, M_O, 1, 0, 1);

    // Randomized traffic against the reference model.
    drive(1, 0, 0, 0, 0, C_NOP);
    model_step();
    tick();
    chk("rand_reset", e_inst, e_vld, e_mode, m_q.size(), e_ill, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 11) == 0), rand_inst());
      model_step();
      tick();
      chk($sformatf("rand%0d", c), e_inst, e_vld, e_mode, m_q.size(), e_ill,
          (m_st == 0) && (e_mode == M_O));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
